seg7_scan_decoder: RTL and testbench

Receive-side counterpart to the team's 7-segment encoder LUT. It samples a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the 5-bit digit code shown on each digit position. Each pattern must be stable for a configurable number of cycles before it is committed, which filters scan transitions and ghosting. Typical uses are loop-back self-test of display drivers and capture of external display buses.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_inv_lut.sv | 33 +++
 rtl/seg7_scan_decoder.sv | 101 ++++++++++
 tb/tb_seg7_scan_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment/code constants and select-decode helper for the 7-segment
// encoder and its receive-side scan decoder.
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 5;

    // Active-low segment patterns, bit0=a .. bit6=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;
    localparam logic [CODE_W-1:0] CODE_ERR   = 5'h1F;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } selInfo_t;

    // Index of the single low bit in an 8-bit active-low select; valid only if exactly one is low.
    function automatic selInfo_t onehot_low_idx(input logic [7:0] sel);
        selInfo_t   info;
        logic [3:0] zeros;
        info  = '0;
        zeros = 4'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!sel[i]) begin
                zeros    = zeros + 4'd1;
                info.idx = 3'(i);
            end
        end
        info.valid = (zeros == 4'd1);
        return info;
    endfunction

endpackage

// File: rtl/seg7_inv_lut.sv
// Inverse of the 7-segment encoder LUT: active-low pattern to hex/blank/error code.
module seg7_inv_lut
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  pattern,
    output logic [CODE_W-1:0] code_c
);

    always_comb begin
        code_c = CODE_ERR;
        case (pattern)
            SEG_0:     code_c = 5'h00;
            SEG_1:     code_c = 5'h01;
            SEG_2:     code_c = 5'h02;
            SEG_3:     code_c = 5'h03;
            SEG_4:     code_c = 5'h04;
            SEG_5:     code_c = 5'h05;
            SEG_6:     code_c = 5'h06;
            SEG_7:     code_c = 5'h07;
            SEG_8:     code_c = 5'h08;
            SEG_9:     code_c = 5'h09;
            SEG_A:     code_c = 5'h0A;
            SEG_B:     code_c = 5'h0B;
            SEG_C:     code_c = 5'h0C;
            SEG_D:     code_c = 5'h0D;
            SEG_E:     code_c = 5'h0E;
            SEG_F:     code_c = 5'h0F;
            SEG_BLANK: code_c = CODE_BLANK;
            default:   code_c = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit codes from a multiplexed active-low 7-segment bus,
// committing a pattern only after it has been stable for STABLE_CYC samples.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [SEG_W-1:0]           iSEG,
    input  logic [DIGITS-1:0]          iDIG_SEL,
    output logic [CODE_W*DIGITS-1:0]   oDIG,
    output logic [DIGITS-1:0]          oVALID,
    output logic [DIGITS-1:0]          oERR,
    output logic                       oUPD,
    output logic [2:0]                 oUPD_IDX
);

    localparam int unsigned SLOT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYC);

    logic [SEG_W-1:0]  sSeg, pSeg;
    logic [DIGITS-1:0] sSel, pSel;
    logic [7:0]        stabCnt, cntNext;
    logic [7:0]        selPad;
    selInfo_t          selInfo;
    logic [SLOT_W-1:0] slot;
    logic              pairSame;
    logic              commit;
    logic              codeChanged;
    logic [CODE_W-1:0] decCode;
    logic [CODE_W-1:0] digMem [DIGITS];

    seg7_inv_lut uInvLut (
        .pattern (sSeg),
        .code_c  (decCode)
    );

    // Stability counter and single-shot commit detection on the sampled pair
    always_comb begin
        selPad = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            selPad[i] = sSel[i];
        end
        selInfo  = onehot_low_idx(selPad);
        slot     = SLOT_W'(selInfo.idx);
        pairSame = (sSeg == pSeg) && (sSel == pSel);

        if (!selInfo.valid) begin
            cntNext = 8'd0;
        end else if (!pairSame) begin
            cntNext = 8'd1;
        end else if (stabCnt >= STAB_MAX) begin
            cntNext = STAB_MAX;
        end else begin
            cntNext = stabCnt + 8'd1;
        end

        commit      = (cntNext == STAB_MAX) && (stabCnt != STAB_MAX);
        codeChanged = (digMem[slot] != decCode) || !oVALID[slot];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sSeg     <= SEG_BLANK;
            pSeg     <= SEG_BLANK;
            sSel     <= '1;
            pSel     <= '1;
            stabCnt  <= 8'd0;
            oVALID   <= '0;
            oERR     <= '0;
            oUPD     <= 1'b0;
            oUPD_IDX <= 3'd0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digMem[i] <= CODE_BLANK;
            end
        end else begin
            sSeg    <= iSEG;
            sSel    <= iDIG_SEL;
            pSeg    <= sSeg;
            pSel    <= sSel;
            stabCnt <= cntNext;
            oUPD    <= 1'b0;
            if (commit) begin
                digMem[slot] <= decCode;
                oVALID[slot] <= 1'b1;
                oERR[slot]   <= (decCode == CODE_ERR);
                if (codeChanged) begin
                    oUPD     <= 1'b1;
                    oUPD_IDX <= selInfo.idx;
                end
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : gDigOut
        assign oDIG[CODE_W*k +: CODE_W] = digMem[k];
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder at DIGITS=4, STABLE_CYC=4.
module tb_seg7_scan_decoder;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [6:0]  iSEG;
    logic [3:0]  iDIG_SEL;
    logic [19:0] oDIG;
    logic [3:0]  oVALID;
    logic [3:0]  oERR;
    logic        oUPD;
    logic [2:0]  oUPD_IDX;

    int nCmp  = 0;
    int nFail = 0;
    int updCnt = 0;
    int base;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iSEG     (iSEG),
        .iDIG_SEL (iDIG_SEL),
        .oDIG     (oDIG),
        .oVALID   (oVALID),
        .oERR     (oERR),
        .oUPD     (oUPD),
        .oUPD_IDX (oUPD_IDX)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oUPD === 1'b1) updCnt++;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
        iDIG_SEL = sel;
        iSEG     = seg;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        iDIG_SEL = 4'hF;
        iSEG = 7'h7F;
        repeat (2) tick();
        iRST = 1'b0;
        tick();
        nCmp++; if (oDIG !== 20'h84210) begin nFail++; $display("FAIL reset_dig got=%h exp=84210", oDIG); end
        nCmp++; if (oVALID !== 4'h0) begin nFail++; $display("FAIL reset_valid got=%b exp=0000", oVALID); end
        nCmp++; if (oERR !== 4'h0) begin nFail++; $display("FAIL reset_err got=%b exp=0000", oERR); end
        nCmp++; if (oUPD !== 1'b0 || oUPD_IDX !== 3'd0) begin nFail++; $display("FAIL reset_upd got=%b/%0d exp=0/0", oUPD, oUPD_IDX); end
    endtask

    task automatic test_single_digit();
        base = updCnt;
        drive(4'b1110, 7'b0100100, 4);
        nCmp++; if (oVALID !== 4'b0000) begin nFail++; $display("FAIL single_early got=%b exp=0000", oVALID); end
        tick();
        nCmp++; if (oDIG[4:0] !== 5'h02) begin nFail++; $display("FAIL single_code got=%h exp=02", oDIG[4:0]); end
        nCmp++; if (oVALID !== 4'b0001) begin nFail++; $display("FAIL single_valid got=%b exp=0001", oVALID); end
        nCmp++; if (oUPD !== 1'b1 || oUPD_IDX !== 3'd0) begin nFail++; $display("FAIL single_upd got=%b/%0d exp=1/0", oUPD, oUPD_IDX); end
        tick();
        nCmp++; if (oUPD !== 1'b0) begin nFail++; $display("FAIL single_upd_drop got=%b exp=0", oUPD); end
        repeat (10) tick();
        nCmp++; if (updCnt - base !== 1) begin nFail++; $display("FAIL single_pulses got=%0d exp=1", updCnt - base); end
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic test_full_scan();
        logic [3:0] sels [4];
        logic [6:0] segs [4];
        sels = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        segs = '{7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110};
        base = updCnt;
        for (int d = 0; d < 4; d++) drive(sels[d], segs[d], 6);
        drive(4'hF, 7'h7F, 2);
        nCmp++; if (oDIG !== {5'h0F, 5'h0E, 5'h0E, 5'h0B}) begin nFail++; $display("FAIL scan_codes got=%h exp=%h", oDIG, {5'h0F, 5'h0E, 5'h0E, 5'h0B}); end
        nCmp++; if (oVALID !== 4'hF) begin nFail++; $display("FAIL scan_valid got=%b exp=1111", oVALID); end
        nCmp++; if (updCnt - base !== 4) begin nFail++; $display("FAIL scan_pulses got=%0d exp=4", updCnt - base); end
        nCmp++; if (oUPD_IDX !== 3'd3) begin nFail++; $display("FAIL scan_idx_hold got=%0d exp=3", oUPD_IDX); end
        base = updCnt;
        for (int d = 0; d < 4; d++) drive(sels[d], segs[d], 6);
        drive(4'hF, 7'h7F, 2);
        nCmp++; if (updCnt - base !== 0) begin nFail++; $display("FAIL rescan_pulses got=%0d exp=0", updCnt - base); end
        nCmp++; if (oDIG !== {5'h0F, 5'h0E, 5'h0E, 5'h0B}) begin nFail++; $display("FAIL rescan_codes got=%h", oDIG); end
    endtask

    task automatic test_glitch();
        base = updCnt;
        drive(4'b1101, 7'b1111001, 3);
        drive(4'b1101, 7'b1111000, 1);
        drive(4'b1101, 7'b1111001, 4);
        nCmp++; if (oDIG[9:5] !== 5'h0E || updCnt - base !== 0) begin nFail++; $display("FAIL glitch_early got=%h/%0d exp=0e/0", oDIG[9:5], updCnt - base); end
        tick();
        nCmp++; if (oDIG[9:5] !== 5'h01) begin nFail++; $display("FAIL glitch_code got=%h exp=01", oDIG[9:5]); end
        nCmp++; if (oUPD !== 1'b1 || oUPD_IDX !== 3'd1) begin nFail++; $display("FAIL glitch_upd got=%b/%0d exp=1/1", oUPD, oUPD_IDX); end
        drive(4'b1101, 7'b1111001, 5);
        drive(4'hF, 7'h7F, 2);
        nCmp++; if (updCnt - base !== 1) begin nFail++; $display("FAIL glitch_pulses got=%0d exp=1", updCnt - base); end
    endtask

    task automatic test_short_window();
        base = updCnt;
        drive(4'b0111, 7'b1111000, 3);
        drive(4'hF, 7'h7F, 4);
        nCmp++; if (oDIG[19:15] !== 5'h0F || updCnt - base !== 0) begin nFail++; $display("FAIL short_window got=%h/%0d exp=0f/0", oDIG[19:15], updCnt - base); end
    endtask

    task automatic test_bad_select();
        base = updCnt;
        drive(4'b1100, 7'b0000000, 20);
        drive(4'b1111, 7'b0000000, 20);
        nCmp++; if (oDIG !== {5'h0F, 5'h0E, 5'h01, 5'h0B}) begin nFail++; $display("FAIL badsel_codes got=%h", oDIG); end
        nCmp++; if (oVALID !== 4'hF || oERR !== 4'h0) begin nFail++; $display("FAIL badsel_flags got=%b/%b exp=1111/0000", oVALID, oERR); end
        nCmp++; if (updCnt - base !== 0) begin nFail++; $display("FAIL badsel_pulses got=%0d exp=0", updCnt - base); end
    endtask

    task automatic test_unknown_pattern();
        drive(4'b1011, 7'b1010101, 5);
        nCmp++; if (oDIG[14:10] !== 5'h1F) begin nFail++; $display("FAIL unknown_code got=%h exp=1f", oDIG[14:10]); end
        nCmp++; if (oERR !== 4'b0100) begin nFail++; $display("FAIL unknown_err got=%b exp=0100", oERR); end
        nCmp++; if (oUPD !== 1'b1 || oUPD_IDX !== 3'd2) begin nFail++; $display("FAIL unknown_upd got=%b/%0d exp=1/2", oUPD, oUPD_IDX); end
        drive(4'hF, 7'h7F, 2);
        drive(4'b1011, 7'b1000000, 5);
        nCmp++; if (oDIG[14:10] !== 5'h00) begin nFail++; $display("FAIL recover_code got=%h exp=00", oDIG[14:10]); end
        nCmp++; if (oERR !== 4'b0000) begin nFail++; $display("FAIL recover_err got=%b exp=0000", oERR); end
        drive(4'hF, 7'h7F, 2);
    endtask

    task automatic test_reset_mid();
        drive(4'b1110, 7'b0000000, 2);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        nCmp++; if (oDIG !== 20'h84210 || oVALID !== 4'h0 || oERR !== 4'h0) begin nFail++; $display("FAIL midrst_state got=%h/%b/%b", oDIG, oVALID, oERR); end
        nCmp++; if (oUPD !== 1'b0 || oUPD_IDX !== 3'd0) begin nFail++; $display("FAIL midrst_upd got=%b/%0d exp=0/0", oUPD, oUPD_IDX); end
        base = updCnt;
        drive(4'hF, 7'h7F, 6);
        nCmp++; if (oVALID !== 4'h0 || updCnt - base !== 0) begin nFail++; $display("FAIL midrst_nocommit got=%b/%0d exp=0000/0", oVALID, updCnt - base); end
        drive(4'b1101, 7'b0011001, 4);
        nCmp++; if (oVALID !== 4'b0000) begin nFail++; $display("FAIL midrst_early got=%b exp=0000", oVALID); end
        tick();
        nCmp++; if (oDIG !== 20'h84090 || oVALID !== 4'b0010) begin nFail++; $display("FAIL midrst_recommit got=%h/%b exp=84090/0010", oDIG, oVALID); end
    endtask

    initial begin
        iRST = 1'b1;
        iDIG_SEL = 4'hF;
        iSEG = 7'h7F;
        test_reset();
        test_single_digit();
        test_full_scan();
        test_glitch();
        test_short_window();
        test_bad_select();
        test_unknown_pattern();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
